leakyrelu_stream_ctrl: RTL and testbench

LEAKYRELU_STREAM_CTRL -- requirements
Module: leakyrelu_stream_ctrl

---
 rtl/leakyrelu_stream_ctrl.sv | 171 +++++++++++++++++
 tb/tb_leakyrelu_stream_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/leakyrelu_stream_ctrl.sv
// Stream controller for an external, non-stallable leaky-ReLU datapath.
// Bytes are issued into the datapath against credit. A tag shift register
// follows each byte through the pipeline so its result can be captured into
// a small FIFO. Credit counts in-flight plus buffered results, so a result
// always has a free slot when it emerges.
module leakyrelu_stream_ctrl #(
    parameter int PIPE_LAT  = 5,
    parameter int BUF_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  cfg_zero,
    input  logic [15:0] cfg_len,
    output logic        busy,
    output logic        done,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  dp_data,
    output logic [7:0]  dp_zero,
    input  logic [7:0]  dp_result,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int OW = $clog2(BUF_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [7:0]    zero_q;
    logic [15:0]   len_q;
    logic [15:0]   issued;
    logic [15:0]   inflight;
    logic [15:0]   delivered;
    logic [PIPE_LAT:0] tag_sr;
    logic [7:0]    mem [BUF_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [OW-1:0] occ;

    logic fire;
    logic start_go;
    logic buf_wr;
    logic buf_rd;
    logic [16:0] credit_used;

    // Circular pointer advance that also works for non power-of-two depths.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign start_go    = (state == IDLE) && start;
    assign fire        = in_valid && in_ready;
    assign buf_wr      = tag_sr[PIPE_LAT];
    assign buf_rd      = out_valid && out_ready;
    assign credit_used = 17'(inflight) + 17'(occ);

    assign in_ready  = (state == RUN) && (issued < len_q) &&
                       (credit_used < 17'(BUF_DEPTH));
    assign out_valid = (occ != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : 8'd0;
    assign dp_zero   = zero_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and status outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = (cfg_len == 16'd0) ? DONE : RUN;
            end
            RUN: begin
                if (issued == len_q) state_nxt = DRAIN;
            end
            DRAIN: begin
                if ((delivered == len_q) && (inflight == 16'd0) && (occ == '0))
                    state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Job configuration is captured only when a start is accepted in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 8'd0;
            len_q  <= 16'd0;
        end else if (start_go) begin
            zero_q <= cfg_zero;
            len_q  <= cfg_len;
        end
    end

    // Datapath input register: loads on a fire, holds otherwise.
    always_ff @(posedge clk) begin
        if (rst)       dp_data <= 8'd0;
        else if (fire) dp_data <= in_data;
    end

    // Tag shift register marking which pipeline slots carry a live byte.
    always_ff @(posedge clk) begin
        if (rst) tag_sr <= '0;
        else     tag_sr <= {tag_sr[PIPE_LAT-1:0], fire};
    end

    // Job progress counters.
    always_ff @(posedge clk) begin
        if (rst || start_go) begin
            issued    <= 16'd0;
            inflight  <= 16'd0;
            delivered <= 16'd0;
        end else begin
            if (fire)   issued    <= issued + 16'd1;
            if (buf_rd) delivered <= delivered + 16'd1;
            case ({fire, buf_wr})
                2'b10:   inflight <= inflight + 16'd1;
                2'b01:   inflight <= inflight - 16'd1;
                default: inflight <= inflight;
            endcase
        end
    end

    // FIFO pointers and occupancy; a simultaneous write and pop cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (buf_wr) wr_ptr <= ptr_inc(wr_ptr);
            if (buf_rd) rd_ptr <= ptr_inc(rd_ptr);
            case ({buf_wr, buf_rd})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // FIFO storage captures the datapath result as its tag leaves.
    always_ff @(posedge clk) begin
        if (buf_wr) mem[wr_ptr] <= dp_result;
    end

    // The credit scheme must make a write into a full buffer impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(buf_wr && (occ == OW'(BUF_DEPTH))));

endmodule

// File: tb/tb_leakyrelu_stream_ctrl.sv
// Scoreboard bench for leakyrelu_stream_ctrl with a behavioural datapath.
module tb_leakyrelu_stream_ctrl;

    localparam int PL = 5;
    localparam int BD = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  cfg_zero = 8'd0;
    logic [15:0] cfg_len = 16'd0;
    logic        busy, done;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  dp_data, dp_zero, dp_result;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pop_cnt = 0;
    int done_cnt = 0;
    int first_fire_cyc = -1;
    int last_fire_cyc = -1;
    logic [7:0] exp_q[$];

    leakyrelu_stream_ctrl #(.PIPE_LAT(PL), .BUF_DEPTH(BD)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_zero(cfg_zero),
        .cfg_len(cfg_len), .busy(busy), .done(done),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .dp_data(dp_data), .dp_zero(dp_zero), .dp_result(dp_result),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Leaky ReLU around the zero point: slope 1/4 below it.
    function automatic logic [7:0] lrelu(input logic [7:0] x, input logic [7:0] z);
        if (x >= z) return x;
        return z - ((z - x) >> 2);
    endfunction

    // Behavioural datapath: result appears PL cycles after dp_data changes.
    logic [7:0] pipe [PL];
    always @(posedge clk) begin
        pipe[0] <= lrelu(dp_data, dp_zero);
        for (int i = 1; i < PL; i++) pipe[i] <= pipe[i-1];
    end
    assign dp_result = pipe[PL-1];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted output byte.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("out_queue_nonempty", exp_q.size(), 1);
                else begin
                    check("out_data", out_data, exp_q.pop_front());
                    pop_cnt++;
                end
            end
        end
    end

    task automatic start_job(input logic [7:0] z, input logic [15:0] len);
        @(posedge clk); #1;
        start = 1'b1; cfg_zero = z; cfg_len = len;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] x, input logic [7:0] e);
        bit fired = 0;
        in_data = x; in_valid = 1'b1;
        for (int i = 0; i < 200 && !fired; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                fired = 1;
                if (first_fire_cyc < 0) first_fire_cyc = cyc;
                last_fire_cyc = cyc;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("fire_accepted", fired, 1);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy; i++) begin
            @(posedge clk); #1;
        end
        check("job_completes", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, p0, nf, bc, dc, done_at, seen;
        logic [7:0] cur;
        logic [7:0] t1_in  [4] = '{8'd20, 8'd30, 8'd40, 8'd50};
        logic [7:0] t4_in  [4] = '{8'd25, 8'd2, 8'd6, 8'd10};
        logic [7:0] t4_exp [4] = '{8'd25, 8'd8, 8'd9, 8'd10};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dp_data", dp_data, 0);
        check("rst_dp_zero", dp_zero, 0);
        check("rst_out_data", out_data, 0);
        rst = 1'b0;

        // Basic job: bytes above the zero point pass unchanged
        d0 = done_cnt; p0 = pop_cnt; first_fire_cyc = -1;
        start_job(8'd10, 16'd4);
        check("t1_dp_zero", dp_zero, 10);
        fork
            for (int i = 0; i < 4; i++) send_byte(t1_in[i], t1_in[i]);
            begin
                seen = 0;
                for (int i = 0; i < 40 && !seen; i++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        seen = 1;
                        check("t1_first_latency", cyc - first_fire_cyc, 7);
                    end
                end
                check("t1_out_valid_seen", seen, 1);
            end
        join
        check("t1_throughput_span", last_fire_cyc - first_fire_cyc, 3);
        wait_idle(100);
        check("t1_pops", pop_cnt - p0, 4);
        check("t1_done_pulses", done_cnt - d0, 1);

        // Backpressure: credit allows exactly BD bytes with out_ready low
        d0 = done_cnt; p0 = pop_cnt; out_ready = 1'b0;
        start_job(8'd0, 16'd16);
        nf = 0; in_valid = 1'b1; in_data = 8'd1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (in_ready) begin exp_q.push_back(in_data); nf++; end
            @(posedge clk); #1;
            in_data = 8'(nf * 7 + 1);
        end
        check("t2_fires_before_stall", nf, 8);
        check("t2_in_ready_stalled", in_ready, 0);
        check("t2_head_while_stalled", out_data, 1);
        check("t2_out_valid_stalled", out_valid, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 200 && nf < 16; i++) begin
            @(negedge clk);
            if (in_ready) begin exp_q.push_back(in_data); nf++; end
            @(posedge clk); #1;
            in_data = 8'(nf * 7 + 1);
        end
        in_valid = 1'b0;
        check("t2_fires_total", nf, 16);
        wait_idle(200);
        check("t2_pops", pop_cnt - p0, 16);
        check("t2_done_pulses", done_cnt - d0, 1);

        // Zero-length job: start is in cycle 0, done appears in cycle 1
        d0 = done_cnt;
        start_job(8'd0, 16'd0);
        bc = 0; dc = 0; done_at = -1; seen = 0;
        for (int k = 1; k <= 6; k++) begin
            bc += int'(busy);
            if (done) begin dc++; if (done_at < 0) done_at = k; end
            if (in_ready || out_valid) seen = 1;
            @(posedge clk); #1;
        end
        check("t3_busy_cycles", bc, 1);
        check("t3_done_cycles", dc, 1);
        check("t3_done_cycle", done_at, 1);
        check("t3_no_stream_activity", seen, 0);
        check("t3_done_count", done_cnt - d0, 1);

        // Start during a job is ignored
        d0 = done_cnt; p0 = pop_cnt;
        start_job(8'd10, 16'd4);
        for (int i = 0; i < 2; i++) send_byte(t4_in[i], t4_exp[i]);
        start = 1'b1; cfg_zero = 8'd3; cfg_len = 16'd1;
        @(posedge clk); #1;
        start = 1'b0;
        check("t4_dp_zero_held", dp_zero, 10);
        check("t4_busy", busy, 1);
        for (int i = 2; i < 4; i++) send_byte(t4_in[i], t4_exp[i]);
        check("t4_dp_zero_drain", dp_zero, 10);
        wait_idle(100);
        repeat (10) @(posedge clk);
        #1;
        check("t4_pops", pop_cnt - p0, 4);
        check("t4_done_pulses", done_cnt - d0, 1);

        // Reset in the middle of a job
        d0 = done_cnt; out_ready = 1'b0;
        start_job(8'd0, 16'd12);
        for (int i = 0; i < 5; i++) send_byte(8'(11 + i), 8'(11 + i));
        repeat (6) @(posedge clk);
        #1;
        check("t5_buffer_filled", out_valid, 1);
        rst = 1'b1; exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        check("t5_in_ready", in_ready, 0);
        check("t5_out_valid", out_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        check("t5_dp_data", dp_data, 0);
        check("t5_dp_zero", dp_zero, 0);
        check("t5_out_data", out_data, 0);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t5_no_done_after_rst", done_cnt - d0, 0);
        p0 = pop_cnt;
        start_job(8'd5, 16'd2);
        send_byte(8'd7, 8'd7);
        send_byte(8'd1, 8'd4);
        wait_idle(100);
        check("t5_new_job_pops", pop_cnt - p0, 2);
        check("t5_new_job_done", done_cnt - d0, 1);

        // Random handshakes over a long job
        d0 = done_cnt; p0 = pop_cnt;
        start_job(8'd128, 16'd1000);
        nf = 0; cur = 8'($urandom_range(0, 255));
        for (int i = 0; i < 20000 && nf < 1000; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data = cur;
            @(negedge clk);
            if (in_valid && in_ready) begin
                exp_q.push_back(lrelu(cur, 8'd128));
                nf++;
                cur = 8'($urandom_range(0, 255));
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("t6_fires", nf, 1000);
        wait_idle(500);
        check("t6_pops", pop_cnt - p0, 1000);
        check("t6_done_pulses", done_cnt - d0, 1);
        check("t6_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
